// File: rtl/cfg_pkg.sv
// cfg_pkg: shared types and default sizes for the configuration loader.
//   cfg_state_t  - loader FSM states
//   LE_LUT_SIZE  - LUT bits per logic element
//   LE_CHAIN_LEN - chain bits per logic element (LUT bits + one mode bit)
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

  localparam int LE_LUT_SIZE  = 16;
  localparam int LE_CHAIN_LEN = LE_LUT_SIZE + 1;

endpackage

// File: rtl/cfg_piso.sv
// cfg_piso: parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears register)
//   load, din - parallel load (has priority over shift)
//   shift     - shift left by one, sin enters at the LSB
//   sin       - serial input (tie low for a pure PISO)
//   msb       - current MSB
//   q         - full register contents
module cfg_piso #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic             msb,
  output logic [WIDTH-1:0] q
);

  // Shift register with load priority over shift
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], sin};
    end else begin
      q <= q;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: serial configuration transmitter for the LE/fabric scan chain.
// Fetches WORD_W-bit words over valid/ready and shifts exactly CHAIN_LEN bits,
// MSB first, into the chain head while config_en is high.
// Optional build macro CFG_LOADER_READBACK_EN adds rb_data/rb_valid, which
// capture the previous chain contents returned on config_data_out.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - one-cycle load request (ignored while busy)
//   s_data/s_valid/s_ready - bitstream word stream
//   config_data_in   - serial bit to chain head
//   config_en        - chain shift enable
//   config_data_out  - serial bit from chain tail
//   busy, done       - load in progress / one-cycle completion pulse
//   rb_data, rb_valid - readback word and strobe (macro only)
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int CHAIN_LEN = LE_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              config_data_in,
  output logic              config_en,
  input  logic              config_data_out,
  output logic              busy,
  output logic              done
`ifdef CFG_LOADER_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int WC_W = $clog2(WORD_W + 1);

  cfg_state_t       state;
  logic [CNT_W-1:0] rem;       // chain bits not yet driven onto config_data_in
  logic [WC_W-1:0]  wcnt;      // bits of the current word still in the PISO
  logic [WC_W-1:0]  take;      // bits to use from the word being accepted
  logic             accept;
  logic             tx_shift;
  logic             tx_msb;
  logic [WORD_W-1:0] tx_q_unused;

  assign accept   = (state == FETCH) && s_valid && s_ready;
  assign tx_shift = (state == SHIFT) && (wcnt != WC_W'(0));

  // Final word may be partial: use only the bits the chain still needs
  always_comb begin
    if (int'(rem) < WORD_W) begin
      take = WC_W'(rem);
    end else begin
      take = WC_W'(WORD_W);
    end
  end

  // The MSB goes straight to config_data_in on accept, so the PISO is loaded
  // pre-shifted and its MSB is always the next bit to send.
  cfg_piso #(.WIDTH(WORD_W)) u_tx_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .din   ({s_data[WORD_W-2:0], 1'b0}),
    .shift (tx_shift),
    .sin   (1'b0),
    .msb   (tx_msb),
    .q     (tx_q_unused)
  );

  // Loader FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      s_ready        <= 1'b0;
      config_en      <= 1'b0;
      config_data_in <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rem            <= '0;
      wcnt           <= '0;
    end else begin
      done      <= 1'b0;
      config_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            s_ready <= 1'b1;
            rem     <= CNT_W'(CHAIN_LEN);
          end
        end
        FETCH: begin
          if (accept) begin
            state          <= SHIFT;
            s_ready        <= 1'b0;
            config_en      <= 1'b1;
            config_data_in <= s_data[WORD_W-1];
            wcnt           <= take - WC_W'(1);
            rem            <= rem - CNT_W'(1);
          end
        end
        SHIFT: begin
          if (wcnt != WC_W'(0)) begin
            config_en      <= 1'b1;
            config_data_in <= tx_msb;
            wcnt           <= wcnt - WC_W'(1);
            rem            <= rem - CNT_W'(1);
          end else if (rem != CNT_W'(0)) begin
            // bubble cycle while the next word is fetched; chain holds
            state   <= FETCH;
            s_ready <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  logic [WORD_W-1:0] rb_q;
  logic [WORD_W-1:0] rb_next;
  logic [WC_W-1:0]   rb_cnt;
  logic              rb_full;
  logic              rb_final;
  logic              rb_msb_unused;

  assign rb_next  = {rb_q[WORD_W-2:0], config_data_out};
  assign rb_full  = config_en && (rb_cnt == WC_W'(WORD_W - 1));
  // rem is already 0 during the cycle that carries the last chain bit
  assign rb_final = config_en && (rem == CNT_W'(0));

  cfg_piso #(.WIDTH(WORD_W)) u_rb_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (rb_full || rb_final),
    .din   ({WORD_W{1'b0}}),
    .shift (config_en),
    .sin   (config_data_out),
    .msb   (rb_msb_unused),
    .q     (rb_q)
  );

  // Readback word assembly; a partial final word is left-justified
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data  <= '0;
      rb_valid <= 1'b0;
      rb_cnt   <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (rb_full) begin
        rb_data  <= rb_next;
        rb_valid <= 1'b1;
        rb_cnt   <= '0;
      end else if (rb_final) begin
        rb_data  <= rb_next << (WC_W'(WORD_W - 1) - rb_cnt);
        rb_valid <= 1'b1;
        rb_cnt   <= '0;
      end else if (config_en) begin
        rb_cnt <= rb_cnt + WC_W'(1);
      end else begin
        rb_cnt <= rb_cnt;
      end
    end
  end
`else
  logic cdo_unused;
  assign cdo_unused = config_data_out;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader with a model scan chain and scoreboards.
module tb_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        config_data_in;
  logic        config_en;
  logic        config_data_out;
  logic        busy;
  logic        done;
`ifdef CFG_LOADER_READBACK_EN
  logic [15:0] rb_data;
  logic        rb_valid;
`endif

  int total = 0;
  int bad   = 0;

  // 17-bit model chain: head gets config_data_in, tail feeds config_data_out
  logic [16:0] chain = 17'h00000;
  logic        pre_load = 1'b0;
  logic [16:0] pre_val = 17'h00000;
  logic        rb_check = 1'b0;

  typedef struct {
    logic [16:0] chain;
    int          done_cyc;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] rb_exp_q[$];

  assign config_data_out = chain[16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_load) chain <= pre_val;
    else if (config_en) chain <= {chain[15:0], config_data_in};
  end

  cfg_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .config_data_in  (config_data_in),
    .config_en       (config_en),
    .config_data_out (config_data_out),
    .busy            (busy),
    .done            (done)
`ifdef CFG_LOADER_READBACK_EN
    ,
    .rb_data         (rb_data),
    .rb_valid        (rb_valid)
`endif
  );

  // One load: start at edge 0, then cycle k is observed at the k-th negedge.
  task automatic do_load(input logic [15:0] w0, input logic [15:0] w1,
                         input int stall, input int busy_at, input int rst_at,
                         input int ncyc, input int exp_done);
    logic [15:0] words[2];
    int idx = 0;
    int stall_left = stall;
    int en_cnt = 0;
    int done_cnt = 0;
    exp_t e;
    logic [15:0] rbe;
    words[0] = w0;
    words[1] = w1;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0; rst = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == busy_at);
      rst   = (k == rst_at);
      if (k == 1) begin
        total++;
        if ({busy, s_ready} !== 2'b11) begin
          bad++; $display("FAIL busy_ready_c1 got=%b exp=11", {busy, s_ready});
        end
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        total++;
        if ({config_en, busy} !== 2'b00) begin
          bad++; $display("FAIL rst_mid_en_busy got=%b exp=00", {config_en, busy});
        end
      end
      if (config_en === 1'b1) en_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_done cycle=%0d", k);
        end else begin
          e = exp_q.pop_front();
          if (chain !== e.chain) begin
            bad++; $display("FAIL chain got=%h exp=%h", chain, e.chain);
          end
          total++;
          if (k != e.done_cyc) begin
            bad++; $display("FAIL done_cycle got=%0d exp=%0d", k, e.done_cyc);
          end
          total++;
          if (en_cnt != 17) begin
            bad++; $display("FAIL en_count got=%0d exp=17", en_cnt);
          end
        end
      end
`ifdef CFG_LOADER_READBACK_EN
      if (rb_check && rb_valid === 1'b1) begin
        total++;
        if (rb_exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_rb_valid got=%h", rb_data);
        end else begin
          rbe = rb_exp_q.pop_front();
          if (rb_data !== rbe) begin
            bad++; $display("FAIL rb_data got=%h exp=%h", rb_data, rbe);
          end
        end
      end
`endif
      // source: offer the next word whenever the loader is ready
      if (s_ready === 1'b1 && idx < 2) begin
        if (idx == 1 && stall_left > 0) begin
          s_valid = 1'b0;
          stall_left--;
        end else begin
          s_valid = 1'b1;
          s_data  = words[idx];
          idx++;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
    start = 1'b0; s_valid = 1'b0; rst = 1'b0;
    total++;
    if (done_cnt != exp_done) begin
      bad++; $display("FAIL done_pulses got=%0d exp=%0d", done_cnt, exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({s_ready, config_en, busy, done} !== 4'b0000) begin
        bad++; $display("FAIL reset_outputs got=%b exp=0000", {s_ready, config_en, busy, done});
      end
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, busy} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset got=%b exp=00", {s_ready, busy});
    end
  endtask

  task automatic test_basic();
    exp_q.push_back('{chain: 17'h16996, done_cyc: 20});
    do_load(16'hB4CB, 16'h0000, 0, 0, 0, 24, 1);
  endtask

  task automatic test_stall();
    exp_q.push_back('{chain: 17'h16996, done_cyc: 25});
    do_load(16'hB4CB, 16'h0000, 5, 0, 0, 30, 1);
  endtask

  task automatic test_start_while_busy();
    exp_q.push_back('{chain: 17'h16996, done_cyc: 20});
    do_load(16'hB4CB, 16'h0000, 0, 8, 0, 26, 1);
  endtask

  task automatic test_reset_mid_load();
    do_load(16'hB4CB, 16'h0000, 0, 0, 10, 24, 0);
    exp_q.push_back('{chain: 17'h00003, done_cyc: 20});
    do_load(16'h0001, 16'h8000, 0, 0, 0, 24, 1);
  endtask

`ifdef CFG_LOADER_READBACK_EN
  task automatic test_readback();
    @(negedge clk);
    pre_val = 17'h16996; pre_load = 1'b1;
    @(negedge clk);
    pre_load = 1'b0;
    rb_check = 1'b1;
    rb_exp_q.push_back(16'hB4CB);
    rb_exp_q.push_back(16'h0000);
    exp_q.push_back('{chain: 17'h00000, done_cyc: 20});
    do_load(16'h0000, 16'h0000, 0, 0, 0, 24, 1);
    rb_check = 1'b0;
    total++;
    if (rb_exp_q.size() != 0) begin
      bad++; $display("FAIL rb_missing got=%0d exp=0", rb_exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_while_busy();
    test_reset_mid_load();
`ifdef CFG_LOADER_READBACK_EN
    test_readback();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL pending_expect got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
Serial configuration transmitter that drives the LE/fabric configuration scan chain: `config_data_in` / `config_en` in, `config_data_out` back.
- Accepts bitstream words over a valid/ready stream.
- Shifts exactly CHAIN_LEN bits into the chain, MSB first, one bit per `clk` while `config_en` is high.
- Sits between the bitstream source (SPI/JTAG front end) and the head of the chain.

Parameters:
- WORD_W, 16, width of incoming bitstream words.
- CHAIN_LEN, 17, total chain bits per load (one LE = LUT_SIZE 16 + 1 mode bit).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- clk  in  1  single clock; the chain shifts on this clock when `config_en`=1.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load.
- s_data  in  WORD_W  bitstream word; MSB is sent first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- config_data_in  out  1  serial bit to the chain head.
- config_en  out  1  chain shift enable; high only when config_data_in carries a real bit.
- config_data_out  in  1  serial bit returned from the chain tail.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last bit is shifted.

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE; s_ready, config_en, config_data_in, busy, done all 0; counters 0.
- All outputs are registered.
- IDLE:
  - start=1 → FETCH, busy=1.
  - start is ignored while busy.
- FETCH:
  - s_ready=1.
  - On s_valid&s_ready: word latched into the PISO, word bit count set to min(WORD_W, remaining) → SHIFT.
  - s_ready is 0 in all other states.
- SHIFT:
  - Each cycle: config_en=1, config_data_in = current PISO MSB, PISO shifts left, remaining decrements.
  - Word exhausted and remaining>0 → FETCH (one bubble cycle, config_en=0, so the chain holds).
  - remaining reaches 0 → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Word count = ceil(CHAIN_LEN/WORD_W).
  - In the final word only the top (CHAIN_LEN - (words-1)*WORD_W) bits are sent.
  - Its low bits are discarded.
- Source stall: s_valid=0 in FETCH holds FETCH with config_en=0; no bit is lost or duplicated.
- Latency, with s_valid held high and defaults (WORD_W 16, CHAIN_LEN 17):
  - start sampled at edge 0.
  - FETCH cycle 1.
  - SHIFT cycles 2–17 (16 bits).
  - FETCH cycle 18.
  - SHIFT cycle 19 (1 bit).
  - done=1 in cycle 20.
- Exactly CHAIN_LEN cycles have config_en=1 per load.
- rst mid-load: config_en drops to 0 at the next edge; state returns to IDLE; no done pulse. Partial chain contents are left as-is.
- start coincident with rst: rst wins.

Optional Feature:
Macro CFG_LOADER_READBACK_EN.
- Defined:
  - Adds outputs rb_data[WORD_W] and rb_valid.
  - Every config_en cycle samples config_data_out, i.e. the previous chain contents, into a readback shift register, MSB-first order matching s_data.
  - rb_valid pulses for one cycle whenever WORD_W bits have been collected, or when the final partial word completes (left-justified, low bits 0).
  - rb_data is reset to 0.
- Undefined: ports absent; config_data_out is unused.

Decomposition:
- Package cfg_pkg:
  - State enum cfg_state_t {IDLE, FETCH, SHIFT, DONE}.
  - Default constants LE_LUT_SIZE=16 and LE_CHAIN_LEN=LE_LUT_SIZE+1.
- One sub-module, cfg_piso:
  - Parallel load, shift enable, MSB out.
  - Parameter WIDTH.
  - Instantiated for transmit, and again for readback under the macro.

Test Plan:
- Reset: hold rst 3 cycles with start=1 → s_ready=0, config_en=0, busy=0, done=0.
- Basic load:
  - Stimulus: start, then words 16'hB4CB and 16'h0000 (XOR LUT 16'h6996 with mode=1).
  - Required: a 17-bit model chain capturing on config_en holds 17'h16996; config_en high exactly 17 cycles; done in cycle 20.
- Stall: drop s_valid for 5 cycles before the second word → config_en stays 0 during the stall; final chain still 17'h16996; done in cycle 25.
- start while busy: pulse start in cycle 8 → ignored; exactly one done pulse and 17 shifts.
- Reset mid-load: assert rst in cycle 10 → config_en=0 next cycle, no done; a following full load of 16'h0001, 16'h8000 yields chain 17'h00003.
- Readback (CFG_LOADER_READBACK_EN):
  - Stimulus: preload chain with 17'h16996, then load all-zero words.
  - Required: rb_data = 16'hB4CB, then 16'h0000, each with one rb_valid pulse.
